// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_ctrl
// Purpose  : Requester-side sequencer for the machine-mode CSR register file.
//            Takes one CSR (RW/RS/RC) or trap (ECALL/MRET) operation from the
//            execute stage, walks it through READ/WRITE/TRAP cycles on the
//            file port and returns old value / redirect over a valid-ready
//            response channel.
// Ports    : clk, rst                      - clock, sync active-high reset
//            req_*                          - operation request (valid/ready)
//            resp_*                         - response (valid/ready, held)
//            csr_addr/inst/wdata1/wdata2/wen - drive the CSR file
//            csr_rdata                      - combinational read data of file
// Revision : 1.0 - initial release
// ============================================================================
module csr_trap_ctrl #(
  parameter int                    ADDR_WIDTH   = 12,
  parameter int                    DATA_WIDTH   = 64,
  parameter logic [ADDR_WIDTH-1:0] INST_ECALL   = 12'h001,
  parameter logic [ADDR_WIDTH-1:0] INST_MRET    = 12'h002,
  parameter int unsigned           MCAUSE_ECALL = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_csr,
  input  logic [DATA_WIDTH-1:0] req_src,
  input  logic                  req_src_x0,
  input  logic [DATA_WIDTH-1:0] req_pc,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_redirect,
  output logic [DATA_WIDTH-1:0] resp_pc,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] csr_addr,
  output logic [ADDR_WIDTH-1:0] csr_inst,
  output logic [DATA_WIDTH-1:0] csr_wdata1,
  output logic [DATA_WIDTH-1:0] csr_wdata2,
  output logic                  csr_wen,
  input  logic [DATA_WIDTH-1:0] csr_rdata
);

  localparam logic [2:0] c_op_rw    = 3'd0;
  localparam logic [2:0] c_op_rs    = 3'd1;
  localparam logic [2:0] c_op_rc    = 3'd2;
  localparam logic [2:0] c_op_ecall = 3'd3;
  localparam logic [2:0] c_op_mret  = 3'd4;
  localparam logic [DATA_WIDTH-1:0] c_mcause_ecall = DATA_WIDTH'(MCAUSE_ECALL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_TRAP  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [2:0]              r_op;
  logic [ADDR_WIDTH-1:0]   r_csr;
  logic [DATA_WIDTH-1:0]   r_src;
  logic                    r_src_x0;
  logic [DATA_WIDTH-1:0]   r_pc;
  logic [DATA_WIDTH-1:0]   r_old;
  logic [DATA_WIDTH-1:0]   r_rpc;
  logic                    r_redirect;
  logic                    r_err;
  logic                    w_in_resp;

  // State register and operation/result latches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_csr      <= '0;
      r_src      <= '0;
      r_src_x0   <= 1'b0;
      r_pc       <= '0;
      r_old      <= '0;
      r_rpc      <= '0;
      r_redirect <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op       <= req_op;
            r_csr      <= req_csr;
            r_src      <= req_src;
            r_src_x0   <= req_src_x0;
            r_pc       <= req_pc;
            // Result fields cleared per operation so traps and illegal ops
            // report rdata=0 and no stale redirect leaks through.
            r_old      <= '0;
            r_rpc      <= '0;
            r_redirect <= 1'b0;
            r_err      <= (req_op > c_op_mret);
          end
        end
        S_READ: begin
          if (r_op == c_op_mret) begin
            r_rpc      <= csr_rdata;   // mepc
            r_redirect <= 1'b1;
          end else begin
            r_old      <= csr_rdata;
          end
        end
        // mtvec is read combinationally in the same cycle the trap write is
        // issued, so it is captured before the file updates.
        S_TRAP: begin
          r_rpc      <= csr_rdata;
          r_redirect <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and CSR-port drive
  always_comb begin
    w_state_nxt = r_state;
    csr_addr    = '0;
    csr_inst    = '0;
    csr_wdata1  = '0;
    csr_wdata2  = '0;
    csr_wen     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_op == c_op_ecall)     w_state_nxt = S_TRAP;
          else if (req_op > c_op_mret)  w_state_nxt = S_RESP;
          else                          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (r_op == c_op_mret) begin
          csr_inst    = INST_MRET;
          w_state_nxt = S_RESP;
        end else begin
          csr_addr = r_csr;
          // Set/clear with a zero source must not write (read-only CSRs).
          if (r_op != c_op_rw && r_src_x0) w_state_nxt = S_RESP;
          else                             w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        csr_addr = r_csr;
        csr_wen  = !rst;
        case (r_op)
          c_op_rs: csr_wdata1 = r_old | r_src;
          c_op_rc: csr_wdata1 = r_old & ~r_src;
          default: csr_wdata1 = r_src;
        endcase
        w_state_nxt = S_RESP;
      end
      S_TRAP: begin
        csr_inst    = INST_ECALL;
        csr_wen     = !rst;
        csr_wdata1  = r_pc;
        csr_wdata2  = c_mcause_ecall;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_in_resp     = (r_state == S_RESP);
  assign req_ready     = (r_state == S_IDLE);
  assign resp_valid    = w_in_resp;
  assign resp_rdata    = w_in_resp ? r_old : '0;
  assign resp_pc       = w_in_resp ? r_rpc : '0;
  assign resp_redirect = w_in_resp & r_redirect;
  assign resp_err      = w_in_resp & r_err;

endmodule
`default_nettype wire

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Multi-cycle sequencer on the requester side of the machine-mode CSR register file port. It accepts one CSR or trap operation from the execute stage and drives the file's `op_addr`/`op_inst`/`wdata1`/`wdata2`/`wen` lines. It captures `rdata` and returns the old CSR value, or a PC redirect for `ecall`/`mret`, over a valid/ready response channel. It sits between the EXU and the CSR file, so no CSR read-modify-write is ever done combinationally in the datapath.

## Interface
- `ADDR_WIDTH`, 12, CSR address / `op_inst` width
- `DATA_WIDTH`, 64, CSR and GPR data width
- `INST_ECALL`, 12'h001, `op_inst` code for ecall; must equal the CSR file's `inst_ecall`
- `INST_MRET`, 12'h002, `op_inst` code for mret; must equal the CSR file's `inst_mret`
- `MCAUSE_ECALL`, 11, cause value written on ecall (zero-extended)

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  EXU presents an operation
- `req_ready`  out  1  block can accept; high only in IDLE
- `req_op`  in  3  0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET, 5–7 illegal
- `req_csr`  in  ADDR_WIDTH  CSR address (ignored for ECALL/MRET)
- `req_src`  in  DATA_WIDTH  rs1 value (or zero-extended immediate)
- `req_src_x0`  in  1  rs1 field/uimm is zero (suppresses write for CSRRS/CSRRC)
- `req_pc`  in  DATA_WIDTH  PC of the instruction (used by ECALL)
- `resp_valid`  out  1  response held until accepted
- `resp_ready`  in  1  EXU accepts response
- `resp_rdata`  out  DATA_WIDTH  old CSR value (0 for ECALL/MRET/illegal)
- `resp_redirect`  out  1  `resp_pc` must be loaded into the PC
- `resp_pc`  out  DATA_WIDTH  redirect target (mtvec or mepc)
- `resp_err`  out  1  illegal `req_op`
- `csr_addr`  out  ADDR_WIDTH  to file `op_addr`
- `csr_inst`  out  ADDR_WIDTH  to file `op_inst`
- `csr_wdata1`  out  DATA_WIDTH  to file `wdata1`
- `csr_wdata2`  out  DATA_WIDTH  to file `wdata2`
- `csr_wen`  out  1  to file `wen`
- `csr_rdata`  in  DATA_WIDTH  from file `rdata` (combinational)

## Operation
- States: IDLE, READ, WRITE, TRAP, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch op, csr, src, src_x0, pc.
  - CSRRW/CSRRS/CSRRC go to READ.
  - MRET goes to READ.
  - ECALL goes to TRAP.
  - Illegal op goes to RESP with err=1.
- READ, CSR ops: `csr_addr`=latched csr, `csr_inst`=0, `csr_wen`=0. Latch `old`=`csr_rdata`.
  - CSRRW goes to WRITE.
  - CSRRS/CSRRC go to WRITE if `src_x0`=0, else RESP (no write).
- READ, MRET: `csr_inst`=INST_MRET, `csr_addr`=0. Latch `csr_rdata` (mepc) as redirect target. Go to RESP with redirect=1. mstatus is not touched.
- WRITE: `csr_addr`=latched csr, `csr_inst`=0, `csr_wen`=1.
  - `csr_wdata1` = src (RW), old|src (RS), old&~src (RC).
  - Go to RESP.
- TRAP: `csr_inst`=INST_ECALL, `csr_wen`=1, `csr_wdata1`=pc, `csr_wdata2`=MCAUSE_ECALL.
  - Latch `csr_rdata` (mtvec, read before the write edge) as redirect target.
  - Go to RESP with redirect=1.
- RESP: `resp_valid`=1. All resp_* outputs stable until `resp_ready`; then go to IDLE.
- CSR-side outputs are all 0 in IDLE and RESP.
- `csr_wen` = (state is WRITE or TRAP) && !rst. No file write ever occurs on a reset edge.
- Unimplemented CSR addresses are not checked here: the file returns 0 and drops the write; the response is normal with rdata=0.

## Timing
- Reset values: IDLE, `req_ready`=1, every other output 0, latched registers 0.
- Handshake at edge 0. Then:
  - CSRRW and RS/RC with write: READ in cycle 1, WRITE in cycle 2, `resp_valid` from cycle 3. The file is updated at the end of cycle 2.
  - RS/RC with `src_x0`=1, and MRET: `resp_valid` from cycle 2.
  - ECALL: TRAP in cycle 1, mepc/mcause updated at end of cycle 1, `resp_valid` from cycle 2.
  - Illegal op: `resp_valid` from cycle 1.
- `req_ready`=0 from the cycle after acceptance until the cycle after the response handshake. There is no overlap and at most one operation is outstanding.
- `resp_valid` with `resp_ready` both high in the same cycle means IDLE next cycle. `resp_ready` is ignored outside RESP.
- `rst` in any state forces IDLE and clears `resp_valid` at the next edge. A pending response or write is discarded.

## Test plan
- After reset, CSRRS with csr=0x300 (mstatus), src=0x8: `resp_rdata`=0xa00001800 at cycle 3; a following CSRRS with `src_x0`=1 returns 0xa00001808.
- CSRRW mtvec(0x305) src=0x8000_0100, then ECALL with pc=0x8000_0040: resp redirect=1, pc=0x8000_0100 at cycle 2. mepc then reads 0x8000_0040 and mcause reads 11.
- MRET after the ECALL above: redirect=1, pc=0x8000_0040. No `csr_wen` pulse during the operation.
- CSRRC mcause(0x342)=11, src=0x3: `resp_rdata`=11, mcause becomes 8. Hold `resp_ready`=0 for 5 cycles: outputs stable and `req_ready`=0 throughout.
- `req_op`=6: `resp_err`=1 at cycle 1, no `csr_wen`. Access to csr=0x7C0: `resp_rdata`=0, err=0.
- Assert `rst` during WRITE of CSRRW mepc=0x1234: mepc remains unchanged, state is IDLE next cycle, `resp_valid` never rises.
